mcp48xx_dac: RTL
================

MCP48XX_DAC -- requirements
Module: mcp48xx_dac

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, giving DAC resolution; legal values are 8, 10 and 12 (MCP4801/4811/4821 and 4802/4812/4822).
REQ-002 The block SHALL have parameter NCH, default 2, giving the channel count; legal values are 1 and 2.
REQ-003 The block SHALL have parameter CLKDIV, default 1, giving the SCK half-period in dacclk cycles; it SHALL be at least 1.
REQ-004 dacclk  in  1  sole clock; all logic is on its rising edge.
REQ-005 dacrstn  in  1  asynchronous, active-low reset.
REQ-006 dacdav  in  1  start request, sampled when idle.
REQ-007 dacdata  in  NCH*DATA_W  per-channel codes; channel k occupies [k*DATA_W +: DATA_W].
REQ-008 daccmd  in  2*NCH  per-channel config {GA_n, SHDN_n}; channel k occupies [2k+1:2k].
REQ-009 dacmask  in  NCH  channel-update enables; bit k=1 means channel k is sent.
REQ-010 dacout  out  1  MOSI, MSB first.
REQ-011 dacsck  out  1  SCLK, idle low; the DAC samples on the rising edge.
REQ-012 dacsync  out  1  CS_n, active low.
REQ-013 dacldac  out  1  LDAC_n, active low, pulsed once per transaction.
REQ-014 dacbusy  out  1  high from acceptance until the end of the LDAC pulse.
REQ-015 davdac  out  1  one-cycle done pulse.

Function
REQ-016 Acceptance: when the state is IDLE and dacdav=1 on an edge, the block SHALL latch dacdata, daccmd and dacmask on that edge and set dacbusy=1 on the same edge; later input changes SHALL have no effect until the next acceptance.
REQ-017 dacdav SHALL be ignored while dacbusy=1.
REQ-018 If dacdav is held high, a new transaction SHALL be accepted in the first IDLE cycle after DONE.
REQ-019 Frame: each frame SHALL be 16 bits: [15]=channel index (A=0, B=1), [14]=0, [13]=GA_n, [12]=SHDN_n, [11:0]=code<<(12-DATA_W), with the low pad bits 0.
REQ-020 Order: enabled channels SHALL be sent in ascending index, one frame each; disabled channels SHALL be skipped.
REQ-021 States SHALL be IDLE, SETUP, SHIFT, HOLD, GAP, LDAC and DONE.
REQ-022 SETUP: D=CLKDIV cycles; dacsync=0, dacsck=0, dacout=bit15.
REQ-023 SHIFT: 16 bits, each lasting 2D cycles (D with SCK low, then D with SCK high); dacout SHALL change only on the SCK falling edge, to the next bit.
REQ-024 HOLD: D cycles; dacsck=0, dacsync=0.
REQ-025 GAP: D cycles; dacsync=1.
REQ-026 After GAP, the block SHALL go to SETUP for the next enabled channel, otherwise to LDAC.
REQ-027 LDAC: D cycles; dacldac=0, dacsync=1.
REQ-028 DONE: 1 cycle; davdac=1, dacbusy=0; the next state SHALL be IDLE.
REQ-029 Latency: davdac SHALL be high exactly n*35*D + D cycles after the acceptance edge, where n is the popcount of the mask.
REQ-030 Empty mask: IDLE SHALL go directly to DONE, with no SCK, SYNC or LDAC activity, and davdac SHALL be high on the cycle after acceptance.
REQ-031 A divider counter SHALL wrap from D-1 to 0, and the bit counter SHALL wrap from 15 to 0 between frames.
REQ-032 Outside SETUP, SHIFT and HOLD, dacsync SHALL be 1, dacsck 0 and dacout 0.

Reset
REQ-033 dacrstn=0 SHALL immediately force: state IDLE, dacsync=1, dacsck=0, dacout=0, dacldac=1, dacbusy=0, davdac=0, and all counters and latches to 0.
REQ-034 A reset mid-frame SHALL abort the transaction without an LDAC pulse; the first acceptance after release SHALL restart from the lowest enabled channel.

Structure
REQ-035 Package mcp48xx_pkg SHALL hold the state enum, FRAME_W=16, the frame bit-position constants (CH, GA, SHDN, DATA_MSB) and the legal DATA_W set.
REQ-036 Sub-module dac_sck_div SHALL be a CLKDIV-cycle tick generator, restartable, that supplies the phase enables to the FSM.
REQ-037 Illegal parameter values SHALL be rejected at elaboration.

Verification
REQ-038 NCH=2, DATA_W=12, D=1, mask=11, data A=0xABC, B=0x123, cmd=11 -> frames 0x3ABC then 0xB123 captured on SCK rises, one LDAC low pulse of 1 cycle, davdac 71 cycles after acceptance.
REQ-039 DATA_W=8, D=3, mask=10, B=0xFF, cmd=01 -> single frame 0x9FF0, SCK half-period 3 cycles, davdac at 108 cycles.
REQ-040 mask=00 -> davdac the cycle after acceptance; dacsync, dacsck and dacldac never toggle.
REQ-041 dacdav held high with dacdata changed during busy -> the first transaction uses the latched data, the second starts the cycle after DONE with the new data.
REQ-042 dacrstn pulsed low mid-SHIFT of channel A -> outputs reach reset values asynchronously, no LDAC pulse; a fresh request completes normally.
REQ-043 Pulse dacdav while busy -> ignored; exactly one davdac pulse results.

Source files
------------

// File: rtl/mcp48xx_dac_pkg.sv
// Shared types and frame layout for the MCP48xx SPI DAC driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcp48xx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_LDAC,
        ST_DONE
    } state_t;

    localparam int FRAME_W = 16;
    localparam int CODE_W  = 12;

    // Bit positions inside the 16-bit write command
    localparam int FRM_CH       = 15;
    localparam int FRM_GA       = 13;
    localparam int FRM_SHDN     = 12;
    localparam int FRM_DATA_MSB = 11;

    // MCP4801/4811/4821 (and dual variants) resolutions
    localparam int LEGAL_DATA_W [3] = '{8, 10, 12};

    function automatic bit legal_data_w(input int w);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (LEGAL_DATA_W[i] == w) ok = 1'b1;
        end
        return ok;
    endfunction

    // Bit 14 is "don't care" on the part and is always driven 0
    function automatic logic [FRAME_W-1:0] make_frame(input logic ch, input logic ga_n,
                                                      input logic shdn_n,
                                                      input logic [CODE_W-1:0] code);
        logic [FRAME_W-1:0] f;
        f                   = '0;
        f[FRM_CH]           = ch;
        f[FRM_GA]           = ga_n;
        f[FRM_SHDN]         = shdn_n;
        f[FRM_DATA_MSB:0]   = code;
        return f;
    endfunction

endpackage

// File: rtl/mcp48xx_dac_if.sv
// Request/status and SPI pin bundle between a host and mcp48xx_dac.
// Latency: n/a (wiring only).
// Backpressure: host must only raise dacdav while dacbusy is low to be sure it is seen.
interface mcp48xx_dac_if #(
    parameter int DATA_W = 12,
    parameter int NCH    = 2
);
    logic                  dacdav;
    logic [NCH*DATA_W-1:0] dacdata;
    logic [2*NCH-1:0]      daccmd;
    logic [NCH-1:0]        dacmask;
    logic                  dacout;
    logic                  dacsck;
    logic                  dacsync;
    logic                  dacldac;
    logic                  dacbusy;
    logic                  davdac;

    modport master (
        output dacdav, dacdata, daccmd, dacmask,
        input  dacout, dacsck, dacsync, dacldac, dacbusy, davdac
    );

    modport slave (
        input  dacdav, dacdata, daccmd, dacmask,
        output dacout, dacsck, dacsync, dacldac, dacbusy, davdac
    );
endinterface

// File: rtl/mcp48xx_dac_sck_div.sv
// Phase-enable generator: o_tick marks the last cycle of every CLKDIV-cycle phase.
// Latency: first tick CLKDIV cycles after i_restart drops.
// Backpressure: none; i_restart holds the count at zero.
module dac_sck_div #(
    parameter int CLKDIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    // Count 0..CLKDIV-1 and wrap; restart pins the count at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mcp48xx_dac.sv
// Serialises one 16-bit write per enabled channel to an MCP48xx, then pulses LDAC_n.
// Latency: davdac n*35*CLKDIV + CLKDIV cycles after acceptance (next cycle for an empty mask).
// Backpressure: requests are ignored while dacbusy is high; a held dacdav is taken on the first IDLE cycle.
module mcp48xx_dac
    import mcp48xx_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int NCH    = 2,
    parameter int CLKDIV = 1
) (
    input  logic            dacclk,
    input  logic            dacrstn,
    mcp48xx_dac_if.slave    bus
);

    if (!legal_data_w(DATA_W)) begin : g_bad_data_w
        $error("mcp48xx_dac: DATA_W must be 8, 10 or 12");
    end
    if (NCH != 1 && NCH != 2) begin : g_bad_nch
        $error("mcp48xx_dac: NCH must be 1 or 2");
    end
    if (CLKDIV < 1) begin : g_bad_clkdiv
        $error("mcp48xx_dac: CLKDIV must be at least 1");
    end

    // Lowest set bit wins so channels go out in ascending order
    function automatic int first_set(input logic [NCH-1:0] m);
        int idx;
        idx = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (m[k]) idx = k;
        end
        return idx;
    endfunction

    state_t                r_state, w_state_n;
    logic                  r_half, w_half_n;          // 0: SCK low phase, 1: SCK high phase
    logic [3:0]            r_bit, w_bit_n;
    logic [FRAME_W-1:0]    r_shreg, w_shreg_n;
    logic [NCH-1:0]        r_pend, w_pend_n;          // channels still to send
    logic [NCH*DATA_W-1:0] r_data, w_data_n;
    logic [2*NCH-1:0]      r_cmd, w_cmd_n;

    logic                  r_sync, r_sck, r_out, r_ldac, r_busy, r_dav;

    logic                  w_restart, w_tick;
    logic [NCH-1:0]        w_src_mask, w_pend_left;
    logic [NCH*DATA_W-1:0] w_src_data;
    logic [2*NCH-1:0]      w_src_cmd;
    logic [DATA_W-1:0]     w_code;
    logic [CODE_W-1:0]     w_code12;
    logic [FRAME_W-1:0]    w_frame;
    logic                  w_in_frame;
    int                    w_sel;

    dac_sck_div #(.CLKDIV(CLKDIV)) u_div (
        .clk       (dacclk),
        .rst_n     (dacrstn),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // Build the next frame: from the live inputs on acceptance, else from the latches
    always_comb begin
        w_src_mask  = (r_state == ST_IDLE) ? bus.dacmask : r_pend;
        w_src_data  = (r_state == ST_IDLE) ? bus.dacdata : r_data;
        w_src_cmd   = (r_state == ST_IDLE) ? bus.daccmd  : r_cmd;
        w_sel       = first_set(w_src_mask);
        w_code      = w_src_data[w_sel*DATA_W +: DATA_W];
        w_code12    = CODE_W'(w_code) << (CODE_W - DATA_W);
        w_frame     = make_frame(1'(w_sel), w_src_cmd[2*w_sel+1], w_src_cmd[2*w_sel], w_code12);
        w_pend_left = w_src_mask & ~(NCH'(1) << w_sel);
    end

    // Next-state and datapath updates; every phase advances on the divider tick
    always_comb begin
        w_state_n = r_state;
        w_half_n  = r_half;
        w_bit_n   = r_bit;
        w_shreg_n = r_shreg;
        w_pend_n  = r_pend;
        w_data_n  = r_data;
        w_cmd_n   = r_cmd;
        w_restart = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_restart = 1'b1;
                if (bus.dacdav) begin
                    w_data_n = bus.dacdata;
                    w_cmd_n  = bus.daccmd;
                    w_pend_n = bus.dacmask;
                    w_half_n = 1'b0;
                    w_bit_n  = '0;
                    if (bus.dacmask == '0) begin
                        w_state_n = ST_DONE;
                    end else begin
                        w_state_n = ST_SETUP;
                        w_shreg_n = w_frame;
                        w_pend_n  = w_pend_left;
                    end
                end
            end
            ST_SETUP: begin
                if (w_tick) w_state_n = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (!r_half) begin
                        w_half_n = 1'b1;
                    end else begin
                        // SCK falling edge: advance to the next bit
                        w_half_n = 1'b0;
                        w_bit_n  = r_bit + 4'd1;
                        if (r_bit == 4'd15) begin
                            w_state_n = ST_HOLD;
                        end else begin
                            w_shreg_n = {r_shreg[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) w_state_n = ST_GAP;
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (r_pend != '0) begin
                        w_state_n = ST_SETUP;
                        w_shreg_n = w_frame;
                        w_pend_n  = w_pend_left;
                    end else begin
                        w_state_n = ST_LDAC;
                    end
                end
            end
            ST_LDAC: begin
                if (w_tick) w_state_n = ST_DONE;
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
                w_restart = 1'b1;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign w_in_frame = (w_state_n == ST_SETUP) || (w_state_n == ST_SHIFT) ||
                        (w_state_n == ST_HOLD);

    // State register plus registered (glitch-free) pin outputs decoded from the next state
    always_ff @(posedge dacclk or negedge dacrstn) begin
        if (!dacrstn) begin
            r_state <= ST_IDLE;
            r_half  <= 1'b0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_pend  <= '0;
            r_data  <= '0;
            r_cmd   <= '0;
            r_sync  <= 1'b1;
            r_sck   <= 1'b0;
            r_out   <= 1'b0;
            r_ldac  <= 1'b1;
            r_busy  <= 1'b0;
            r_dav   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_half  <= w_half_n;
            r_bit   <= w_bit_n;
            r_shreg <= w_shreg_n;
            r_pend  <= w_pend_n;
            r_data  <= w_data_n;
            r_cmd   <= w_cmd_n;
            r_sync  <= !w_in_frame;
            r_sck   <= (w_state_n == ST_SHIFT) && w_half_n;
            r_out   <= w_in_frame ? w_shreg_n[FRAME_W-1] : 1'b0;
            r_ldac  <= (w_state_n != ST_LDAC);
            r_busy  <= (w_state_n != ST_IDLE) && (w_state_n != ST_DONE);
            r_dav   <= (w_state_n == ST_DONE);
        end
    end

    assign bus.dacout  = r_out;
    assign bus.dacsck  = r_sck;
    assign bus.dacsync = r_sync;
    assign bus.dacldac = r_ldac;
    assign bus.dacbusy = r_busy;
    assign bus.davdac  = r_dav;

endmodule
